ddr_rd_arbiter: RTL and testbench
=================================

// Module: ddr_rd_arbiter
// PURPOSE
//  Two-port round-robin arbiter that shares the single DDR3 EMIF read command port
//  (Avalon-MM style: read/addr/burstcount/ready, rddata/rddata_valid).
//  req0 = pattern fetch/send engine, req1 = secondary reader (frame/header loader).
//  Tracks in-flight bursts in an ID FIFO and routes each returned beat to its issuer.
//  Sits between the requesters and the EMIF; write side is not touched.
// PARAMETERS
//  ADDR_W   22   DDR word address width
//  DATA_W   256  read data width
//  BURST_W  5    burstcount width; legal values 1..16
//  OUTS_LOG2 3   log2 of max outstanding bursts (ID FIFO depth = 8)
// PORTS
//  ddr_emif_clk           in   1        sole clock
//  ddr_emif_rst_n         in   1        async active-low reset
//  reqN_read (N=0,1)      in   1        read request; held with addr/burst until reqN_ack
//  reqN_addr              in   ADDR_W   burst start address
//  reqN_burst_count       in   BURST_W  beats requested
//  reqN_ack               out  1        1-cycle pulse: command accepted by EMIF
//  reqN_rddata_valid      out  1        returned beat belongs to requester N
//  req_rddata             out  DATA_W   returned data, shared by both requesters
//  ddr_emif_ready         in   1        EMIF accepts command when high
//  ddr_emif_read          out  1        read command
//  ddr_emif_addr          out  ADDR_W   command address
//  ddr_emif_burst_count   out  BURST_W  command burst length
//  ddr_emif_read_data     in   DATA_W   read data
//  ddr_emif_rddata_valid  in   1        read data beat valid
//  err_unexpected         out  1        sticky: beat returned with no burst in flight
// BEHAVIOUR
//  Reset: ddr_emif_read=0, addr/burst=0, reqN_ack=0, reqN_rddata_valid=0, err=0,
//   FSM=IDLE, ID FIFO empty, beat counter=0, last_grant=1 (req0 wins first tie).
//  FSM IDLE: if any reqN_read and ID FIFO not full -> pick winner, register its
//   addr/burst into ddr_emif_*, set grant_id, ddr_emif_read=1 next cycle, -> ISSUE.
//   Request seen cycle T -> ddr_emif_read high cycle T+1.
//  Round robin: both requesting -> grant the one != last_grant; single requester
//   always wins. last_grant updates on grant.
//  FSM ISSUE: hold ddr_emif_read/addr/burst stable until ddr_emif_ready=1.
//   Accept cycle: reqN_ack (N=grant_id) combinationally high, push {grant_id,burst}
//   into ID FIFO; next cycle ddr_emif_read=0, -> IDLE. Min 2 cycles per command.
//  Requester drops or changes read/addr the cycle after its ack; IDLE never samples
//   a request in the same cycle an ack is issued.
//  burst_count 0 is issued as 1 (stored and sent as 1).
//  Return path (combinational): req_rddata = ddr_emif_read_data;
//   reqN_rddata_valid = ddr_emif_rddata_valid & FIFO non-empty & head.id==N.
//  Beat counter counts valid beats of head entry; on beat == head.burst: pop, cnt=0.
//  Push and pop in same cycle: both performed, occupancy unchanged.
//  FIFO full (8 in flight): IDLE stalls; ISSUE already holding completes normally
//   (ISSUE only entered with room, so push never overflows).
//  rddata_valid with FIFO empty: beat dropped, no reqN_rddata_valid, err_unexpected=1
//   until reset.
//  Reset mid-operation: all state cleared immediately; in-flight bursts are lost.
//  Arithmetic: occupancy OUTS_LOG2+1 bits; pointers wrap mod 2^OUTS_LOG2.
// TESTING
//  req0 only, addr 0x10 burst 4, ready=1 -> read high 1 cycle, ack0 once, 4 beats on
//   req0_rddata_valid only.
//  req0+req1 held together, 4 commands each -> grants 0,1,0,1..., acks alternate.
//  ready low 5 cycles during ISSUE -> addr/burst stable, single ack on ready rise.
//  10 bursts issued, no returns -> 8 accepted, 9th stalls in IDLE; first pop frees
//   slot and 9th issues next IDLE cycle.
//  interleave: req1 burst 2 then req0 burst 3, return 5 beats back-to-back ->
//   beats 1-2 to req1, 3-5 to req0; push on final pop cycle keeps count correct.
//  stray rddata_valid at empty -> err_unexpected=1, no valid outputs; reset clears.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_rd_arbiter
//
// Purpose:
//   Shares the single DDR3 EMIF read command port between two requesters
//   with round-robin arbitration. Each accepted command is remembered in an
//   ID FIFO as {requester id, burst length}. Returned beats are routed to the
//   requester at the head of that FIFO. The write side of the EMIF is not
//   handled here.
//
//   req0 is the pattern fetch/send engine. req1 is the secondary reader
//   (frame/header loader).
//
// Handshake:
//   A requester raises reqN_read with reqN_addr/reqN_burst_count and holds
//   them until reqN_ack. reqN_ack is a single-cycle pulse, high in the cycle
//   the EMIF accepts the command (ddr_emif_read & ddr_emif_ready). The
//   requester drops or changes its request in the following cycle. On the
//   EMIF side, ddr_emif_read/addr/burst_count stay stable until
//   ddr_emif_ready is seen high.
//
// Ports:
//   ddr_emif_clk, ddr_emif_rst_n   clock, async active-low reset
//   reqN_read/addr/burst_count     request from requester N (N = 0, 1)
//   reqN_ack                       command accepted for requester N
//   reqN_rddata_valid              returned beat belongs to requester N
//   req_rddata                     returned data, shared by both requesters
//   ddr_emif_ready/read/addr/burst_count   EMIF command port
//   ddr_emif_read_data/rddata_valid        EMIF read return
//   err_unexpected                 sticky: beat arrived with nothing in flight
//   dbg_state                      current FSM state (0 = IDLE, 1 = ISSUE)
// ---------------------------------------------------------------------------
module ddr_rd_arbiter #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 256,
    parameter int BURST_W   = 5,
    parameter int OUTS_LOG2 = 3
) (
    input  logic               ddr_emif_clk,
    input  logic               ddr_emif_rst_n,

    input  logic               req0_read,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic [BURST_W-1:0] req0_burst_count,
    output logic               req0_ack,
    output logic               req0_rddata_valid,

    input  logic               req1_read,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic [BURST_W-1:0] req1_burst_count,
    output logic               req1_ack,
    output logic               req1_rddata_valid,

    output logic [DATA_W-1:0]  req_rddata,

    input  logic               ddr_emif_ready,
    output logic               ddr_emif_read,
    output logic [ADDR_W-1:0]  ddr_emif_addr,
    output logic [BURST_W-1:0] ddr_emif_burst_count,
    input  logic [DATA_W-1:0]  ddr_emif_read_data,
    input  logic               ddr_emif_rddata_valid,

    output logic               err_unexpected,
    output logic               dbg_state
);

    localparam int                 DEPTH      = 1 << OUTS_LOG2;
    localparam logic [OUTS_LOG2:0] FIFO_DEPTH = (OUTS_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Command-side state.
    state_e               state_q,      state_d;
    logic                 emif_read_q,  emif_read_d;
    logic [ADDR_W-1:0]    emif_addr_q,  emif_addr_d;
    logic [BURST_W-1:0]   emif_burst_q, emif_burst_d;
    logic                 grant_id_q,   grant_id_d;
    logic                 last_grant_q, last_grant_d;

    // In-flight burst tracking.
    logic [OUTS_LOG2-1:0] wr_ptr_q,     wr_ptr_d;
    logic [OUTS_LOG2-1:0] rd_ptr_q,     rd_ptr_d;
    logic [OUTS_LOG2:0]   count_q,      count_d;
    logic [BURST_W-1:0]   beat_cnt_q,   beat_cnt_d;
    logic                 err_q,        err_d;

    // Storage is qualified by count_q, so it needs no reset.
    logic                 fifo_id_q    [DEPTH];
    logic [BURST_W-1:0]   fifo_burst_q [DEPTH];

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 head_id;
    logic [BURST_W-1:0]   head_burst;
    logic                 accept;
    logic                 beat_ok;
    logic                 pop;
    logic                 win_id;
    logic [ADDR_W-1:0]    win_addr;
    logic [BURST_W-1:0]   win_burst_raw;
    logic [BURST_W-1:0]   win_burst;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_DEPTH);
    assign head_id    = fifo_id_q[rd_ptr_q];
    assign head_burst = fifo_burst_q[rd_ptr_q];

    // The accept cycle is also the FIFO push cycle.
    assign accept = (state_q == ST_ISSUE) && ddr_emif_ready;

    // Round robin: on a tie the requester that did not win last time wins.
    // A lone requester always wins.
    assign win_id        = req1_read & (~req0_read | ~last_grant_q);
    assign win_addr      = win_id ? req1_addr        : req0_addr;
    assign win_burst_raw = win_id ? req1_burst_count : req0_burst_count;
    // A zero-length burst would never return a beat and would block the
    // FIFO head forever, so it is issued as a single beat.
    assign win_burst     = (win_burst_raw == '0) ? BURST_W'(1) : win_burst_raw;

    // Return path.
    assign beat_ok = ddr_emif_rddata_valid && !fifo_empty;
    assign pop     = beat_ok && ((beat_cnt_q + 1'b1) == head_burst);

    assign req_rddata        = ddr_emif_read_data;
    assign req0_rddata_valid = beat_ok && (head_id == 1'b0);
    assign req1_rddata_valid = beat_ok && (head_id == 1'b1);

    assign req0_ack = accept && (grant_id_q == 1'b0);
    assign req1_ack = accept && (grant_id_q == 1'b1);

    assign ddr_emif_read        = emif_read_q;
    assign ddr_emif_addr        = emif_addr_q;
    assign ddr_emif_burst_count = emif_burst_q;
    assign err_unexpected       = err_q;
    assign dbg_state            = state_q;

    // Command FSM next state.
    always_comb begin
        state_d      = state_q;
        emif_read_d  = emif_read_q;
        emif_addr_d  = emif_addr_q;
        emif_burst_d = emif_burst_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                // Only start a command if its ID entry is guaranteed room,
                // so the push in ISSUE can never overflow.
                if ((req0_read || req1_read) && !fifo_full) begin
                    grant_id_d   = win_id;
                    last_grant_d = win_id;
                    emif_addr_d  = win_addr;
                    emif_burst_d = win_burst;
                    emif_read_d  = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ddr_emif_ready) begin
                    emif_read_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                emif_read_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // ID FIFO bookkeeping and beat counting.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (beat_ok) begin
            if (pop) begin
                beat_cnt_d = '0;
                rd_ptr_d   = rd_ptr_q + 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        // A beat with nothing in flight is dropped and flagged.
        if (ddr_emif_rddata_valid && fifo_empty) begin
            err_d = 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
        if (!ddr_emif_rst_n) begin
            state_q      <= ST_IDLE;
            emif_read_q  <= 1'b0;
            emif_addr_q  <= '0;
            emif_burst_q <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            emif_read_q  <= emif_read_d;
            emif_addr_q  <= emif_addr_d;
            emif_burst_q <= emif_burst_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge ddr_emif_clk) begin
        if (accept) begin
            fifo_id_q[wr_ptr_q]    <= grant_id_q;
            fifo_burst_q[wr_ptr_q] <= emif_burst_q;
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_arbiter
//
// Purpose:
//   Self-checking bench for ddr_rd_arbiter. A transaction-level reference
//   model (a queue of outstanding bursts plus the round-robin rule) predicts
//   every output each cycle. Directed scenarios are followed by randomized
//   traffic, including a reset in the middle of activity.
// ---------------------------------------------------------------------------
module tb_ddr_rd_arbiter;

    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 256;
    localparam int BURST_W   = 5;
    localparam int OUTS_LOG2 = 3;
    localparam int MAX_OUT   = 1 << OUTS_LOG2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic               r_read  [2];
    logic [ADDR_W-1:0]  r_addr  [2];
    logic [BURST_W-1:0] r_burst [2];
    logic               rdy = 1'b0;
    logic               rdv = 1'b0;
    logic [DATA_W-1:0]  rdata = '0;

    logic               req0_ack, req1_ack;
    logic               req0_rddata_valid, req1_rddata_valid;
    logic [DATA_W-1:0]  req_rddata;
    logic               ddr_emif_read;
    logic [ADDR_W-1:0]  ddr_emif_addr;
    logic [BURST_W-1:0] ddr_emif_burst_count;
    logic               err_unexpected;
    logic               dbg_state;

    ddr_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .OUTS_LOG2(OUTS_LOG2)
    ) dut (
        .ddr_emif_clk          (clk),
        .ddr_emif_rst_n        (rst_n),
        .req0_read             (r_read[0]),
        .req0_addr             (r_addr[0]),
        .req0_burst_count      (r_burst[0]),
        .req0_ack              (req0_ack),
        .req0_rddata_valid     (req0_rddata_valid),
        .req1_read             (r_read[1]),
        .req1_addr             (r_addr[1]),
        .req1_burst_count      (r_burst[1]),
        .req1_ack              (req1_ack),
        .req1_rddata_valid     (req1_rddata_valid),
        .req_rddata            (req_rddata),
        .ddr_emif_ready        (rdy),
        .ddr_emif_read         (ddr_emif_read),
        .ddr_emif_addr         (ddr_emif_addr),
        .ddr_emif_burst_count  (ddr_emif_burst_count),
        .ddr_emif_read_data    (rdata),
        .ddr_emif_rddata_valid (rdv),
        .err_unexpected        (err_unexpected),
        .dbg_state             (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Outstanding bursts in issue order: owner and beats still to come.
    bit                own_q[$];
    int                rem_q[$];
    bit                m_issuing, m_gnt, m_last, m_err;
    logic [ADDR_W-1:0] m_addr;
    int                m_burst;
    bit                ack_seen [2];

    // Observations of DUT outputs for directed scenario checks.
    int                cnt_ack  [2];
    int                cnt_beat [2];
    int                cnt_read;
    bit                ack_log[$];
    bit                beat_log[$];

    task automatic model_reset();
        own_q.delete();
        rem_q.delete();
        m_issuing = 0;
        m_gnt     = 0;
        m_last    = 1;
        m_err     = 0;
        m_addr    = '0;
        m_burst   = 0;
    endtask

    task automatic model_step();
        int old_sz;
        bit push_p;
        bit w;
        old_sz = own_q.size();
        push_p = 0;
        if (m_issuing) begin
            if (rdy) begin
                push_p    = 1;
                m_issuing = 0;
            end
        end else if ((r_read[0] || r_read[1]) && old_sz < MAX_OUT) begin
            if (r_read[0] && r_read[1]) w = !m_last;
            else                        w = r_read[1];
            m_last    = w;
            m_gnt     = w;
            m_addr    = r_addr[w];
            m_burst   = (r_burst[w] == 0) ? 1 : int'(r_burst[w]);
            m_issuing = 1;
        end
        if (rdv) begin
            if (old_sz == 0) begin
                m_err = 1;
            end else begin
                rem_q[0] = rem_q[0] - 1;
                if (rem_q[0] == 0) begin
                    void'(own_q.pop_front());
                    void'(rem_q.pop_front());
                end
            end
        end
        if (push_p) begin
            own_q.push_back(m_gnt);
            rem_q.push_back(m_burst);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        bit e_ack0, e_ack1, e_v0, e_v1;
        if (!rst_n) model_reset();
        e_ack0 = m_issuing && rdy && !m_gnt;
        e_ack1 = m_issuing && rdy && m_gnt;
        e_v0 = 0;
        e_v1 = 0;
        if (rdv && own_q.size() > 0) begin
            e_v0 = (own_q[0] == 1'b0);
            e_v1 = (own_q[0] == 1'b1);
        end
        check("emif_read", ddr_emif_read, m_issuing);
        if (m_issuing) begin
            check("emif_addr",  ddr_emif_addr,        m_addr);
            check("emif_burst", ddr_emif_burst_count, m_burst);
        end
        check("ack0",   req0_ack,          e_ack0);
        check("ack1",   req1_ack,          e_ack1);
        check("valid0", req0_rddata_valid, e_v0);
        check("valid1", req1_rddata_valid, e_v1);
        check("err",    err_unexpected,    m_err);
        if (rdv) check("rddata", req_rddata, rdata);

        if (req0_ack) begin cnt_ack[0]++; ack_log.push_back(1'b0); end
        if (req1_ack) begin cnt_ack[1]++; ack_log.push_back(1'b1); end
        if (req0_rddata_valid) begin cnt_beat[0]++; beat_log.push_back(1'b0); end
        if (req1_rddata_valid) begin cnt_beat[1]++; beat_log.push_back(1'b1); end
        if (ddr_emif_read) cnt_read++;

        ack_seen[0] = e_ack0;
        ack_seen[1] = e_ack1;
        if (rst_n) model_step();
    end

    // ---------------- driver ----------------
    int                 cmds_left [2];
    int                 req_pct = 0;
    int                 rdy_pct = 100;
    int                 ret_pct = 0;
    int                 rdy_low_cnt = 0;
    bit                 use_dir = 0;
    logic [ADDR_W-1:0]  dir_addr = '0;
    logic [BURST_W-1:0] dir_burst = '0;
    bit                 stray = 0;

    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            if (r_read[n] && !ack_seen[n]) continue;
            if (cmds_left[n] > 0 && $urandom_range(0, 99) < req_pct) begin
                r_read[n]  = 1'b1;
                r_addr[n]  = use_dir ? dir_addr  : ADDR_W'($urandom);
                r_burst[n] = use_dir ? dir_burst : BURST_W'($urandom_range(0, 16));
                cmds_left[n]--;
            end else begin
                r_read[n] = 1'b0;
            end
        end
        if (rdy_low_cnt > 0) begin
            rdy = 1'b0;
            rdy_low_cnt--;
        end else begin
            rdy = ($urandom_range(0, 99) < rdy_pct);
        end
        rdv   = stray || (own_q.size() > 0 && $urandom_range(0, 99) < ret_pct);
        stray = 0;
        rdata = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic clear_obs();
        cnt_ack[0] = 0;  cnt_ack[1] = 0;
        cnt_beat[0] = 0; cnt_beat[1] = 0;
        cnt_read = 0;
        ack_log.delete();
        beat_log.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            r_read[n] = 1'b0;
            cmds_left[n] = 0;
        end
        rdy = 1'b0;
        rdv = 1'b0;
        rdy_low_cnt = 0;
        stray = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_obs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int n = 0; n < 2; n++) begin
            r_read[n] = 1'b0; r_addr[n] = '0; r_burst[n] = '0;
            cmds_left[n] = 0; ack_seen[n] = 0;
        end
        model_reset();
        clear_obs();
        apply_reset();

        // Single req0 burst of 4 at 0x10, always-ready EMIF.
        use_dir = 1; dir_addr = ADDR_W'(32'h10); dir_burst = BURST_W'(4);
        req_pct = 100; rdy_pct = 100; ret_pct = 100;
        cmds_left[0] = 1;
        tick(15);
        check("single_acks0",  cnt_ack[0],  1);
        check("single_acks1",  cnt_ack[1],  0);
        check("single_reads",  cnt_read,    1);
        check("single_beats0", cnt_beat[0], 4);
        check("single_beats1", cnt_beat[1], 0);

        // Both requesters held together: grants must alternate 0,1,0,1...
        apply_reset();
        dir_burst = BURST_W'(2); ret_pct = 0;
        cmds_left[0] = 4; cmds_left[1] = 4;
        tick(30);
        check("rr_count", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size() && i < 8; i++)
            check($sformatf("rr_grant%0d", i), ack_log[i], i % 2);
        ret_pct = 100;
        tick(30);

        // EMIF not ready for 5 cycles while a command is pending.
        apply_reset();
        dir_addr = ADDR_W'(32'h2A); dir_burst = BURST_W'(7);
        cmds_left[1] = 1; rdy_low_cnt = 6;
        tick(25);
        check("stall_acks1", cnt_ack[1], 1);
        check("stall_reads", cnt_read,   6);
        check("stall_beats", cnt_beat[1], 7);

        // Ten single-beat bursts with no returns: only 8 fit.
        apply_reset();
        dir_burst = BURST_W'(1); ret_pct = 0;
        cmds_left[0] = 10;
        tick(40);
        check("full_acks", cnt_ack[0], 8);
        ret_pct = 100;
        tick(40);
        check("full_acks_after", cnt_ack[0],  10);
        check("full_beats",      cnt_beat[0], 10);

        // req1 burst 2 then req0 burst 3, data returned back-to-back.
        apply_reset();
        ret_pct = 0; dir_burst = BURST_W'(2); cmds_left[1] = 1;
        tick(6);
        dir_burst = BURST_W'(3); cmds_left[0] = 1;
        tick(6);
        ret_pct = 100;
        tick(12);
        check("ilv_beats", beat_log.size(), 5);
        for (int i = 0; i < beat_log.size() && i < 5; i++)
            check($sformatf("ilv_owner%0d", i), beat_log[i], (i < 2) ? 1 : 0);

        // Stray beat with nothing in flight, then reset clears the flag.
        apply_reset();
        stray = 1;
        tick(4);
        check("stray_err",    err_unexpected, 1'b1);
        check("stray_beats0", cnt_beat[0], 0);
        check("stray_beats1", cnt_beat[1], 0);
        apply_reset();
        #3;
        check("stray_err_cleared", err_unexpected, 1'b0);

        // Randomized traffic with a reset in the middle of activity.
        use_dir = 0;
        cmds_left[0] = 100000; cmds_left[1] = 100000;
        for (int blk = 0; blk < 20; blk++) begin
            req_pct = $urandom_range(20, 100);
            rdy_pct = $urandom_range(20, 100);
            ret_pct = $urandom_range(10, 100);
            tick(100);
            if (blk == 10) begin
                apply_reset();
                cmds_left[0] = 100000; cmds_left[1] = 100000;
            end
        end
        cmds_left[0] = 0; cmds_left[1] = 0;
        rdy_pct = 100; ret_pct = 100;
        tick(200);
        check("drain_idle", ddr_emif_read, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
